// File: rtl/uart2ahb_pkg.sv
// Shared definitions for the uart2ahb bridge: auto-baud FSM encoding and default sizing.
package uart2ahb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } ab_state_t;

  localparam int CNT_W_DEF    = 18;
  localparam int OSR_LOG2_DEF = 4;
  localparam int DIV_MIN      = 2;

endpackage

// File: rtl/uart_autobaud_gen_if.sv
// Serial input, control and status bundle of the auto-baud generator.
interface uart_autobaud_gen_if
  import uart2ahb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             ser_in;
  logic             mode_manual;
  logic [CNT_W-1:0] manual_div;
  logic             relock;
  logic             baud_tick;
  logic             locked;
  logic [CNT_W-1:0] div_value;
  logic             err_short;
  logic             err_timeout;

  modport slave (
    input  ser_in, mode_manual, manual_div, relock,
    output baud_tick, locked, div_value, err_short, err_timeout
  );

  modport master (
    output ser_in, mode_manual, manual_div, relock,
    input  baud_tick, locked, div_value, err_short, err_timeout
  );
endinterface

// File: rtl/uart_baud_tick_div.sv
// Down-counting divider: one-cycle baud_tick every div cycles, restarted by load.
module uart_baud_tick_div #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] div,
  output logic             baud_tick
);

  logic [CNT_W-1:0] cnt;

  // Count down to zero, then reload; a load restarts the period from div-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (div == '0) begin
      cnt <= '0;
    end else if (load || cnt == '0) begin
      cnt <= div - CNT_W'(1);
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Tick is suppressed in the load cycle so the first tick lands div cycles later.
  assign baud_tick = (div != '0) && (cnt == '0) && !load;

endmodule

// File: rtl/uart_autobaud_gen.sv
// Auto-baud detector: measures the minimum edge-to-edge interval on ser_in,
// derives the oversample divider and drives the baud tick generator.
module uart_autobaud_gen
  import uart2ahb_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int OSR_LOG2 = OSR_LOG2_DEF,
  parameter int NUM_INT  = 8
) (
  input logic                clk,
  input logic                rst_n,
  uart_autobaud_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1, s2, s3;
  logic             any_edge, fall;
  logic [CNT_W-1:0] cnt, interval, min_q, min_new, d, man_sel, div_q;
  logic [7:0]       int_cnt;
  logic             last_int, load;
  logic             locked_q, err_short_q, err_timeout_q;
  ab_state_t        state;

  assign any_edge = s2 ^ s3;
  assign fall     = s3 & ~s2;
  assign interval = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
  assign min_new  = (interval < min_q) ? interval : min_q;
  assign d        = min_new >> OSR_LOG2;
  assign last_int = (int_cnt == 8'(NUM_INT - 1));
  assign man_sel  = (bus.manual_div >= CNT_W'(DIV_MIN)) ? bus.manual_div : '0;

  // Synchroniser plus history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: reset to 1 (line idle) so releasing reset on a high line is not seen as an edge.
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop samples its predecessor's pre-edge value.
      s1 <= bus.ser_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Saturating edge-to-edge interval counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (any_edge) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Calibration FSM with registered status and divider outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      min_q         <= '1;
      int_cnt       <= '0;
      div_q         <= '0;
      load          <= 1'b0;
      locked_q      <= 1'b0;
      err_short_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      load          <= 1'b0;
      err_short_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      if (bus.mode_manual) begin
        state    <= ST_IDLE;
        locked_q <= 1'b0;
        div_q    <= man_sel;
        load     <= (man_sel != div_q);
      end else if (bus.relock) begin
        state    <= ST_IDLE;
        locked_q <= 1'b0;
        div_q    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            div_q <= '0;
            if (fall) begin
              state   <= ST_MEASURE;
              min_q   <= '1;
              int_cnt <= '0;
            end
          end
          ST_MEASURE: begin
            if (any_edge) begin
              min_q   <= min_new;
              int_cnt <= int_cnt + 8'd1;
              if (last_int) begin
                if (d >= CNT_W'(DIV_MIN)) begin
                  state    <= ST_LOCKED;
                  locked_q <= 1'b1;
                  div_q    <= d;
                  load     <= 1'b1;
                end else begin
                  state       <= ST_IDLE;
                  err_short_q <= 1'b1;
                end
              end
            end else if (cnt == CNT_MAX) begin
              state         <= ST_IDLE;
              min_q         <= '1;
              err_timeout_q <= 1'b1;
            end
          end
          ST_LOCKED: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.locked      = locked_q;
  assign bus.div_value   = div_q;
  assign bus.err_short   = err_short_q;
  assign bus.err_timeout = err_timeout_q;

  uart_baud_tick_div #(.CNT_W(CNT_W)) u_tick_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .div       (div_q),
    .baud_tick (bus.baud_tick)
  );

endmodule

// File: tb/tb_uart_autobaud_gen.sv
// Directed bench for uart_autobaud_gen with an event scoreboard and tick timing log.
module tb_uart_autobaud_gen;
  import uart2ahb_pkg::*;

  localparam int CNT_W = 12;

  typedef enum int {EV_LOCK = 1, EV_SHORT = 2, EV_TIMEOUT = 3} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       div;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_autobaud_gen_if #(.CNT_W(CNT_W)) bus ();

  uart_autobaud_gen #(.CNT_W(CNT_W), .OSR_LOG2(4), .NUM_INT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lock_cyc = 0;
  int   tick_q[$];
  exp_t exp_q[$];
  logic locked_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.baud_tick, bus.locked, bus.err_short, bus.err_timeout, bus.div_value});
  endfunction

  task automatic sb_event(input ev_kind_t k, input int dv);
    exp_t e;
    check("sb_event_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_event_kind", 32'(k), 32'(e.kind));
      check("sb_event_div", 32'(dv), 32'(e.div));
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: log ticks, route status events to the scoreboard.
  always @(negedge clk) begin
    if (bus.baud_tick === 1'b1) tick_q.push_back(cyc);
    if (bus.locked === 1'b1 && locked_prev !== 1'b1) begin
      lock_cyc = cyc;
      sb_event(EV_LOCK, int'(bus.div_value));
    end
    if (bus.err_short === 1'b1) sb_event(EV_SHORT, 0);
    if (bus.err_timeout === 1'b1) sb_event(EV_TIMEOUT, 0);
    locked_prev = bus.locked;
  end

  task automatic expect_ev(input ev_kind_t k, input int dv);
    exp_t e;
    e.kind = k;
    e.div  = dv;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bt);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.ser_in = fr[i];
      repeat (bt) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_ticks(input string tag, input int period, input int n, input bit from_lock);
    check({tag, "_count"}, 32'(tick_q.size() >= n), 32'd1);
    if (from_lock && tick_q.size() > 0)
      check({tag, "_first"}, 32'(tick_q[0] - lock_cyc), 32'(period));
    for (int i = 1; i < n && i < tick_q.size(); i++)
      check({tag, "_period"}, 32'(tick_q[i] - tick_q[i-1]), 32'(period));
  endtask

  task automatic calibrate(input string tag, input int bt, input int div);
    expect_ev(EV_LOCK, div);
    tick_q.delete();
    send_byte(8'h55, bt);
    repeat (40) @(negedge clk);
    wait_drain({tag, "_drain"}, 100);
    check({tag, "_locked"}, 32'(bus.locked), 32'd1);
    check({tag, "_div"}, 32'(bus.div_value), 32'(div));
    check_ticks({tag, "_ticks"}, div, 8, 1'b1);
  endtask

  initial begin
    bus.ser_in      = 1'b1;
    bus.mode_manual = 1'b0;
    bus.manual_div  = '0;
    bus.relock      = 1'b0;
    rst_n           = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_outputs", outs(), 32'd0);

    // 1: bit time 160 -> divider 10
    calibrate("t1", 160, 10);

    // 5: relock coincident with a synchronised line edge
    bus.ser_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_locked_before", 32'(bus.locked), 32'd1);
    bus.relock = 1'b1;
    @(negedge clk);
    bus.relock = 1'b0;
    check("t5_locked_dropped", 32'(bus.locked), 32'd0);
    check("t5_div_cleared", 32'(bus.div_value), 32'd0);
    tick_q.delete();
    repeat (40) @(negedge clk);
    check("t5_ticks_stopped", 32'(tick_q.size()), 32'd0);
    bus.ser_in = 1'b1;
    repeat (30) @(negedge clk);
    calibrate("t5_recal", 320, 20);

    // 2: bit time 16 -> divider 1, rejected
    bus.relock = 1'b1;
    @(negedge clk);
    bus.relock = 1'b0;
    repeat (10) @(negedge clk);
    expect_ev(EV_SHORT, 0);
    tick_q.delete();
    send_byte(8'h55, 16);
    repeat (40) @(negedge clk);
    wait_drain("t2_drain", 100);
    check("t2_outputs", outs(), 32'd0);
    check("t2_no_ticks", 32'(tick_q.size()), 32'd0);

    // 3: start edge then stuck low -> counter saturation
    expect_ev(EV_TIMEOUT, 0);
    bus.ser_in = 1'b0;
    repeat (4200) @(negedge clk);
    wait_drain("t3_drain", 200);
    check("t3_outputs", outs(), 32'd0);
    bus.ser_in = 1'b1;
    repeat (30) @(negedge clk);
    calibrate("t3_recal", 160, 10);

    // 4: manual divider
    bus.mode_manual = 1'b1;
    bus.manual_div  = CNT_W'(7);
    repeat (3) @(negedge clk);
    check("t4_locked_off", 32'(bus.locked), 32'd0);
    tick_q.delete();
    repeat (60) @(negedge clk);
    check("t4_div", 32'(bus.div_value), 32'd7);
    check_ticks("t4_ticks", 7, 6, 1'b0);
    bus.relock = 1'b1;
    @(negedge clk);
    bus.relock = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_relock_ignored", 32'(bus.div_value), 32'd7);
    bus.manual_div = CNT_W'(1);
    repeat (3) @(negedge clk);
    tick_q.delete();
    repeat (40) @(negedge clk);
    check("t4_div1_zero", 32'(bus.div_value), 32'd0);
    check("t4_div1_no_ticks", 32'(tick_q.size()), 32'd0);
    bus.mode_manual = 1'b0;
    repeat (5) @(negedge clk);
    calibrate("t4_auto", 160, 10);

    // 6: asynchronous reset mid-LOCKED and mid-MEASURE
    @(negedge clk);
    check("t6_locked_before", 32'(bus.locked), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("t6_reset_locked", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    bus.ser_in = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t6_reset_measure", outs(), 32'd0);
    bus.ser_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick_q.delete();
    repeat (200) @(negedge clk);
    check("t6_idle_no_ticks", 32'(tick_q.size()), 32'd0);
    check("t6_idle_outputs", outs(), 32'd0);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
